match_grid_engine: RTL and testbench

//  Parametrised ROWS x COLS tile-matching game engine. Successor of the fixed 4x4 lab controller.

---
 rtl/match_grid_engine.sv | 164 ++++++++++++++++
 tb/tb_match_grid_engine.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/match_grid_engine.sv
// match_grid_engine: ROWS x COLS tile-matching game controller with mirror tiles,
// a timed reveal of mismatched pairs and a saturating move counter.
module match_grid_engine #(
    parameter int ROWS = 4,
    parameter int COLS = 4,
    parameter int SYM_W = 3,
    parameter logic [ROWS*COLS*SYM_W-1:0] ANSWER = {3'd7, 3'd7, 3'd0, 3'd1, 3'd6, 3'd6, 3'd5, 3'd5,
                                                    3'd4, 3'd4, 3'd3, 3'd3, 3'd1, 3'd2, 3'd2, 3'd0},
    parameter logic [ROWS*COLS-1:0] MIRROR_INIT = 16'h8208,
    parameter int HOLD_CYCLES = 50_000_000,
    parameter int MOVE_W = 8,
    localparam int N = ROWS*COLS,
    localparam int IDX_W = $clog2(N)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              sel_valid,
    input  logic [IDX_W-1:0]  sel_idx,
    input  logic              sel_mirror,
    input  logic              confirm,
    input  logic              hint,
    output logic [N-1:0]      flipped,
    output logic [N-1:0]      mirrored,
    output logic [N-1:0]      reveal,
    output logic              hint_on,
    output logic              pass,
    output logic [2:0]        state,
    output logic [MOVE_W-1:0] moves
);
    localparam int CNT_W = HOLD_CYCLES > 1 ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [IDX_W:0] N_L = (IDX_W+1)'(N);

    typedef enum logic [2:0] {INIT = 3'd0, SHOW = 3'd1, GAME = 3'd2, HOLD = 3'd3, FINISH = 3'd4} state_t;

    state_t             state_q, state_d;
    logic [N-1:0]       flipped_q, flipped_d, mirrored_q, mirrored_d, reveal_q, reveal_d;
    logic [MOVE_W-1:0]  moves_q, moves_d;
    logic [IDX_W-1:0]   a_q, a_d, b_q, b_d;
    logic               a_v_q, a_v_d, b_v_q, b_v_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               sel_ok, match;

    function automatic logic [SYM_W-1:0] sym(input logic [IDX_W-1:0] i);
        return ANSWER[i*SYM_W +: SYM_W];
    endfunction

    // Out-of-range indices only exist when N is not a power of two.
    assign sel_ok = sel_valid && ({1'b0, sel_idx} < N_L) && !flipped_q[sel_idx];
    assign match = sym(a_q) == sym(b_q) && !mirrored_q[a_q] && !mirrored_q[b_q];

    always_comb begin
        state_d = state_q;
        flipped_d = flipped_q;
        mirrored_d = mirrored_q;
        reveal_d = reveal_q;
        moves_d = moves_q;
        a_d = a_q;
        b_d = b_q;
        a_v_d = a_v_q;
        b_v_d = b_v_q;
        cnt_d = cnt_q;
        case (state_q)
            INIT: if (start) begin
                state_d = SHOW;
                reveal_d = '1;
            end
            SHOW: if (start) begin
                state_d = GAME;
                reveal_d = '0;
                a_v_d = 1'b0;
                b_v_d = 1'b0;
            end
            GAME: if (&flipped_q) begin
                state_d = FINISH;
                mirrored_d = '0;
                reveal_d = '0;
            end else if (!hint && confirm) begin
                if (a_v_q && b_v_q) begin
                    moves_d = &moves_q ? moves_q : moves_q + MOVE_W'(1);
                    if (match) begin
                        flipped_d[a_q] = 1'b1;
                        flipped_d[b_q] = 1'b1;
                        reveal_d = '0;
                        a_v_d = 1'b0;
                        b_v_d = 1'b0;
                    end else begin
                        state_d = HOLD;
                        cnt_d = CNT_W'(HOLD_CYCLES - 1);
                    end
                end else begin
                    reveal_d = '0;
                    a_v_d = 1'b0;
                    b_v_d = 1'b0;
                end
            end else if (!hint && sel_ok) begin
                if (sel_mirror) begin
                    mirrored_d[sel_idx] = ~mirrored_q[sel_idx];
                    reveal_d[sel_idx] = 1'b1;
                end else if (!a_v_q) begin
                    a_d = sel_idx;
                    a_v_d = 1'b1;
                    reveal_d[sel_idx] = 1'b1;
                end else if (sel_idx != a_q && !b_v_q) begin
                    b_d = sel_idx;
                    b_v_d = 1'b1;
                    reveal_d[sel_idx] = 1'b1;
                end
            end
            HOLD: if (cnt_q == '0) begin
                state_d = GAME;
                reveal_d = '0;
                a_v_d = 1'b0;
                b_v_d = 1'b0;
            end else begin
                cnt_d = cnt_q - CNT_W'(1);
            end
            FINISH: begin
                flipped_d = start ? '0 : '1;
                mirrored_d = start ? MIRROR_INIT : '0;
                reveal_d = '0;
                moves_d = start ? '0 : moves_q;
                a_v_d = 1'b0;
                b_v_d = 1'b0;
                state_d = start ? INIT : FINISH;
            end
            default: state_d = INIT;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= INIT;
            flipped_q <= '0;
            mirrored_q <= MIRROR_INIT;
            reveal_q <= '0;
            moves_q <= '0;
            a_q <= '0;
            b_q <= '0;
            a_v_q <= 1'b0;
            b_v_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            state_q <= state_d;
            flipped_q <= flipped_d;
            mirrored_q <= mirrored_d;
            reveal_q <= reveal_d;
            moves_q <= moves_d;
            a_q <= a_d;
            b_q <= b_d;
            a_v_q <= a_v_d;
            b_v_q <= b_v_d;
            cnt_q <= cnt_d;
        end
    end

    assign flipped = flipped_q;
    assign mirrored = mirrored_q;
    assign reveal = reveal_q;
    assign moves = moves_q;
    assign state = state_q;
    assign hint_on = state_q == GAME && hint;
    assign pass = state_q == FINISH;
endmodule

// File: tb/tb_match_grid_engine.sv
// tb_match_grid_engine: directed game scenarios plus random events, checked every
// cycle against an array/queue reference model of the game rules.
module tb_match_grid_engine;
    localparam int N = 16;
    localparam int H = 4;
    localparam logic [N-1:0] MIR0 = 16'h8208;
    localparam logic [N*3-1:0] ANS = {3'd7, 3'd7, 3'd0, 3'd1, 3'd6, 3'd6, 3'd5, 3'd5,
                                      3'd4, 3'd4, 3'd3, 3'd3, 3'd1, 3'd2, 3'd2, 3'd0};
    localparam int S_INIT = 0, S_SHOW = 1, S_GAME = 2, S_HOLD = 3, S_FIN = 4;

    logic clk = 1'b0, rst = 1'b0;
    logic start = 1'b0, sel_valid = 1'b0, sel_mirror = 1'b0, confirm = 1'b0, hint = 1'b0;
    logic [3:0] sel_idx = '0;
    logic [N-1:0] flipped, mirrored, reveal;
    logic hint_on, pass;
    logic [2:0] state;
    logic [7:0] moves;

    int n_vec = 0, n_err = 0;
    int sym_t[N] = '{0, 2, 2, 1, 3, 3, 4, 4, 5, 5, 6, 6, 1, 0, 7, 7};
    bit m_flip[N], m_mir[N], m_rev[N];
    int m_slots[$];
    int m_state, m_moves, m_hold;

    match_grid_engine #(.ROWS(4), .COLS(4), .SYM_W(3), .ANSWER(ANS), .MIRROR_INIT(MIR0),
                        .HOLD_CYCLES(H), .MOVE_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .sel_valid(sel_valid), .sel_idx(sel_idx),
        .sel_mirror(sel_mirror), .confirm(confirm), .hint, .flipped(flipped),
        .mirrored(mirrored), .reveal(reveal), .hint_on, .pass(pass),
        .state(state), .moves(moves)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [N-1:0] pk(input bit v[N]);
        logic [N-1:0] r;
        for (int i = 0; i < N; i++) r[i] = v[i];
        return r;
    endfunction

    task automatic m_reset();
        m_state = S_INIT;
        m_moves = 0;
        m_hold = 0;
        m_slots.delete();
        for (int i = 0; i < N; i++) begin
            m_flip[i] = 0;
            m_mir[i] = MIR0[i];
            m_rev[i] = 0;
        end
    endtask

    task automatic m_set(input bit f, input bit m, input bit r);
        for (int i = 0; i < N; i++) begin
            m_flip[i] = f;
            m_mir[i] = m;
            m_rev[i] = r;
        end
    endtask

    task automatic m_clear_rev();
        for (int i = 0; i < N; i++) m_rev[i] = 0;
    endtask

    task automatic model();
        int a, b, idx, all;
        idx = int'(sel_idx);
        all = 1;
        for (int i = 0; i < N; i++) if (!m_flip[i]) all = 0;
        case (m_state)
            S_INIT: if (start) begin
                m_state = S_SHOW;
                for (int i = 0; i < N; i++) m_rev[i] = 1;
            end
            S_SHOW: if (start) begin
                m_state = S_GAME;
                m_clear_rev();
                m_slots.delete();
            end
            S_GAME: if (all == 1) begin
                m_state = S_FIN;
                m_set(1, 0, 0);
            end else if (!hint) begin
                if (confirm) begin
                    if (m_slots.size() == 2) begin
                        if (m_moves < 255) m_moves++;
                        a = m_slots[0];
                        b = m_slots[1];
                        if (sym_t[a] == sym_t[b] && !m_mir[a] && !m_mir[b]) begin
                            m_flip[a] = 1;
                            m_flip[b] = 1;
                            m_clear_rev();
                            m_slots.delete();
                        end else begin
                            m_state = S_HOLD;
                            m_hold = H;
                        end
                    end else begin
                        m_clear_rev();
                        m_slots.delete();
                    end
                end else if (sel_valid && !m_flip[idx]) begin
                    if (sel_mirror) begin
                        m_mir[idx] = !m_mir[idx];
                        m_rev[idx] = 1;
                    end else if (m_slots.size() == 0 || (m_slots.size() == 1 && m_slots[0] != idx)) begin
                        m_slots.push_back(idx);
                        m_rev[idx] = 1;
                    end
                end
            end
            S_HOLD: begin
                m_hold--;
                if (m_hold == 0) begin
                    m_state = S_GAME;
                    m_clear_rev();
                    m_slots.delete();
                end
            end
            S_FIN: if (start) begin
                m_reset();
            end
            default: ;
        endcase
    endtask

    task automatic cmp();
        chk("state", 32'(state), 32'(m_state));
        chk("flipped", 32'(flipped), 32'(pk(m_flip)));
        chk("mirrored", 32'(mirrored), 32'(pk(m_mir)));
        chk("reveal", 32'(reveal), 32'(pk(m_rev)));
        chk("moves", 32'(moves), 32'(m_moves));
        chk("hint_on", {31'd0, hint_on}, 32'(m_state == S_GAME && hint));
        chk("pass", 32'(pass), 32'(m_state == S_FIN));
    endtask

    task automatic step(input logic st, input logic sv, input int idx, input logic sm,
                        input logic cf, input logic hn);
        start = st;
        sel_valid = sv;
        sel_idx = 4'(idx);
        sel_mirror = sm;
        confirm = cf;
        hint = hn;
        @(posedge clk);
        model();
        #1;
        cmp();
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0);
    endtask

    task automatic sel(input int idx);
        step(0, 1, idx, 0, 0, 0);
    endtask

    task automatic mir(input int idx);
        step(0, 1, idx, 1, 0, 0);
    endtask

    task automatic cnf();
        step(0, 0, 0, 0, 1, 0);
    endtask

    task automatic pair(input int a, input int b);
        sel(a);
        sel(b);
        cnf();
    endtask

    initial begin
        m_reset();
        #12;
        chk("rst_state", 32'(state), 32'(S_INIT));
        chk("rst_mirrored", 32'(mirrored), 32'h8208);
        chk("rst_reveal", 32'(reveal), 32'h0);
        rst = 1'b1;
        @(negedge clk);
        step(1, 0, 0, 0, 0, 0);
        chk("show_state", 32'(state), 32'(S_SHOW));
        chk("show_reveal", 32'(reveal), 32'hFFFF);
        step(1, 0, 0, 0, 0, 0);
        chk("game_state", 32'(state), 32'(S_GAME));
        chk("game_reveal", 32'(reveal), 32'h0);
        // mismatch 0/1: HOLD for exactly H cycles with start/select/confirm ignored
        pair(0, 1);
        chk("mm_state", 32'(state), 32'(S_HOLD));
        chk("mm_reveal", 32'(reveal), 32'h0003);
        for (int k = 0; k < H; k++) begin
            if (k == 1) step(1, 1, 5, 0, 1, 0);
            else idle();
            chk("hold_state", 32'(state), 32'(k < H - 1 ? S_HOLD : S_GAME));
            chk("hold_reveal", 32'(reveal), k < H - 1 ? 32'h0003 : 32'h0);
        end
        pair(0, 13);
        chk("match_flipped", 32'(flipped), 32'h2001);
        chk("match_moves", 32'(moves), 32'd2);
        chk("match_reveal", 32'(reveal), 32'h0);
        pair(3, 12);
        chk("mir_block", 32'(state), 32'(S_HOLD));
        repeat (H) idle();
        mir(3);
        chk("mir_toggle", 32'(mirrored), 32'h8200);
        pair(3, 12);
        chk("mir_match", 32'(flipped), 32'h3009);
        step(0, 1, 1, 0, 0, 1);
        chk("hint_on", {31'd0, hint_on}, 32'd1);
        chk("hint_sel", 32'(reveal), 32'h0);
        step(0, 1, 1, 0, 1, 0);
        chk("cf_sel_drop", 32'(reveal), 32'h0);
        pair(1, 2);
        pair(4, 5);
        pair(6, 7);
        mir(9);
        pair(8, 9);
        pair(10, 11);
        mir(15);
        pair(14, 15);
        chk("all_flipped", 32'(flipped), 32'hFFFF);
        chk("not_yet_fin", 32'(pass), 32'd0);
        idle();
        chk("fin_pass", 32'(pass), 32'd1);
        chk("fin_mirrored", 32'(mirrored), 32'h0);
        step(1, 0, 0, 0, 0, 0);
        chk("restart_state", 32'(state), 32'(S_INIT));
        chk("restart_mirrored", 32'(mirrored), 32'h8208);
        chk("restart_moves", 32'(moves), 32'd0);
        // async reset in the middle of HOLD
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        pair(1, 4);
        idle();
        #2 rst = 1'b0;
        #1;
        m_reset();
        chk("arst_state", 32'(state), 32'(S_INIT));
        chk("arst_reveal", 32'(reveal), 32'h0);
        chk("arst_moves", 32'(moves), 32'd0);
        cmp();
        @(negedge clk);
        rst = 1'b1;
        for (int n = 0; n < 4000; n++)
            step($urandom_range(0, 11) == 0, $urandom_range(0, 2) == 0, int'($urandom_range(0, 15)),
                 $urandom_range(0, 4) == 0, $urandom_range(0, 5) == 0, $urandom_range(0, 9) == 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
